// File: rtl/alu_feed_pkg.sv
// alu_feed_pkg: shared types for the bit-serial ALU operand feeder.
//   op_e       - 3-bit opcode
//   ctrl_t     - decoded slice controls {cmpl_x, cmpl_y, op_xor, op_and, op_arith, cin}
//   alu_out_t  - registered ALU-side output bundle plus the bit-0 framing flag
//   state_e    - feeder FSM states
//   decode_op  - opcode -> ctrl_t
// Optional feature macro: ALU_FEED_B2B_EN (back-to-back words, no GAP state).
package alu_feed_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_RSUB = 3'b010,
        OP_XOR  = 3'b011,
        OP_XNOR = 3'b100,
        OP_AND  = 3'b101,
        OP_ANDN = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef struct packed {
        logic cmpl_x;
        logic cmpl_y;
        logic op_xor;
        logic op_and;
        logic op_arith;
        logic cin;
    } ctrl_t;

    typedef struct packed {
        logic  x;
        logic  y;
        logic  carry_in;
        logic  last;
        ctrl_t ctrl;     // cin field unused on the output side
        logic  first;
    } alu_out_t;

`ifdef ALU_FEED_B2B_EN
    typedef enum logic [0:0] {IDLE, SHIFT} state_e;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
`endif

    function automatic ctrl_t decode_op(op_e op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD:  c = '{cmpl_x: 1'b0, cmpl_y: 1'b0, op_xor: 1'b0, op_and: 1'b0, op_arith: 1'b1, cin: 1'b0};
            OP_SUB:  c = '{cmpl_x: 1'b0, cmpl_y: 1'b1, op_xor: 1'b0, op_and: 1'b0, op_arith: 1'b1, cin: 1'b1};
            OP_RSUB: c = '{cmpl_x: 1'b1, cmpl_y: 1'b0, op_xor: 1'b0, op_and: 1'b0, op_arith: 1'b1, cin: 1'b1};
            OP_XOR:  c = '{cmpl_x: 1'b0, cmpl_y: 1'b0, op_xor: 1'b1, op_and: 1'b0, op_arith: 1'b0, cin: 1'b0};
            OP_XNOR: c = '{cmpl_x: 1'b0, cmpl_y: 1'b1, op_xor: 1'b1, op_and: 1'b0, op_arith: 1'b0, cin: 1'b0};
            OP_AND:  c = '{cmpl_x: 1'b0, cmpl_y: 1'b0, op_xor: 1'b0, op_and: 1'b1, op_arith: 1'b0, cin: 1'b0};
            OP_ANDN: c = '{cmpl_x: 1'b0, cmpl_y: 1'b1, op_xor: 1'b0, op_and: 1'b1, op_arith: 1'b0, cin: 1'b0};
            default: c = '0;  // OP_NOP
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_feed_dly.sv
// alu_feed_dly: DEPTH-stage, 2-bit delay line with async active-low clear.
//   clk_i   clock
//   rst_ni  async active-low clear
//   d_i     2-bit input sampled every rising edge
//   q_o     d_i delayed by DEPTH cycles
module alu_feed_dly #(
    parameter int unsigned DEPTH = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/alu_serial_feeder.sv
// alu_serial_feeder: accepts {in_x, in_y, in_op} over valid/ready and streams the
// operands LSB-first onto X/Y with the decoded slice controls, plus framing
// strobes delayed by PIPE_LAT to line up with the ALU result bits.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     word handshake; in_x/in_y operands, in_op opcode
//   X, Y                  serial operand bits (registered)
//   Carry_in, End         bit-0 carry, bit-(WIDTH-1) marker (registered)
//   Cmpl_X/Y, Op_*        decoded controls held for the word (registered)
//   busy                  word in flight
//   res_first, res_last   bit 0 / bit WIDTH-1 at the ALU outputs
// Optional feature macro: ALU_FEED_B2B_EN (in_ready during the End cycle,
// next word follows End directly; no GAP state).
module alu_serial_feeder
    import alu_feed_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PIPE_LAT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [2:0]       in_op,
    output logic             X,
    output logic             Y,
    output logic             Carry_in,
    output logic             End,
    output logic             Cmpl_X,
    output logic             Cmpl_Y,
    output logic             Op_XOR,
    output logic             Op_AND,
    output logic             Op_ARITH,
    output logic             busy,
    output logic             res_first,
    output logic             res_last
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    ctrl_t            ctrl_q, ctrl_d;
    alu_out_t         out_q, out_d;
    logic             accept;
    logic [1:0]       dly_q;

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ctrl_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ctrl_q  <= ctrl_d;
            out_q   <= out_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            IDLE:  state_d = IDLE;
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
`ifdef ALU_FEED_B2B_EN
                    state_d = IDLE;
`else
                    state_d = GAP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifndef ALU_FEED_B2B_EN
            GAP:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
        // in_ready already restricts acceptance to IDLE (or the End cycle)
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            x_d     = in_x;
            y_d     = in_y;
            ctrl_d  = decode_op(op_e'(in_op));
        end
    end

    // Outputs: ALU-side values are computed from next state so they are registered
    always_comb begin
`ifdef ALU_FEED_B2B_EN
        in_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
`else
        in_ready = (state_q == IDLE);
`endif
        busy  = (state_q != IDLE);
        out_d = '0;
        if (state_d == SHIFT) begin
            out_d.x        = x_d[cnt_d];
            out_d.y        = y_d[cnt_d];
            out_d.carry_in = ctrl_d.cin && (cnt_d == '0);
            out_d.last     = (cnt_d == CNT_LAST);
            out_d.ctrl     = ctrl_d;
            out_d.first    = (cnt_d == '0);
        end
    end

    assign X        = out_q.x;
    assign Y        = out_q.y;
    assign Carry_in = out_q.carry_in;
    assign End      = out_q.last;
    assign Cmpl_X   = out_q.ctrl.cmpl_x;
    assign Cmpl_Y   = out_q.ctrl.cmpl_y;
    assign Op_XOR   = out_q.ctrl.op_xor;
    assign Op_AND   = out_q.ctrl.op_and;
    assign Op_ARITH = out_q.ctrl.op_arith;

    alu_feed_dly #(
        .DEPTH (PIPE_LAT)
    ) u_dly (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    ({out_q.first, out_q.last}),
        .q_o    (dly_q)
    );

    assign res_first = dly_q[1];
    assign res_last  = dly_q[0];

endmodule
